// File: rtl/pb_boot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_boot_seq_pkg
// Description : Shared types and default constants for the boot sequencer:
//               sequencer state encoding, boot-mode encoding and the default
//               memory-mapped register addresses of the boot target.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_boot_seq_pkg;

    // Sequencer states, explicitly encoded on 4 bits
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_PRE  = 4'd1,
        ST_WR_ENTRY  = 4'd2,
        ST_WR_WAKE   = 4'd3,
        ST_POLL_WAIT = 4'd4,
        ST_POLL_REQ  = 4'd5,
        ST_POLL_RESP = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } boot_state_e;

    // Boot source selected at start time
    typedef enum logic [1:0] {
        IDLE_PRELOAD = 2'd0,
        SDCARD       = 2'd1,
        AUTO_SPI     = 2'd2,
        AUTO_I2C     = 2'd3
    } boot_mode_e;

    // Default register map of the boot target
    localparam logic [47:0] c_scratch_addr   = 48'h0300_0000;
    localparam logic [47:0] c_entry_addr     = 48'h0300_0008;
    localparam logic [47:0] c_wake_addr      = 48'h0300_0010;

    // Default watchdog length and the exit code reported when it fires
    localparam logic [31:0] c_timeout_cycles = 32'd10_000_000;
    localparam logic [31:0] c_timeout_code   = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/pb_boot_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : pb_boot_seq_timer
// Description : Up-counting interval timer. i_load restarts the count at zero,
//               i_enable advances it, o_expire flags the enabled cycle in which
//               the count reaches i_terminal (i.e. after i_terminal+1 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module pb_boot_seq_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    // Count register: load has priority so the owner can hold it at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_expire = i_enable && (r_count == i_terminal);

endmodule
`default_nettype wire

// File: rtl/pb_boot_seq.sv
`default_nettype none
// ============================================================================
// Module      : pb_boot_seq
// Description : Boot sequencer. Optionally writes the entry point and wake-up
//               registers of a core, then polls a scratch register until its
//               end-of-computation bit is set and reports the exit code.
//               Define PB_BOOT_SEQ_TIMEOUT_EN to add a watchdog that aborts a
//               busy sequence after TimeoutCycles cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_boot_seq
    import pb_boot_seq_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 64,
    parameter logic [AddrWidth-1:0] ScratchAddr  = AddrWidth'(c_scratch_addr),
    parameter logic [AddrWidth-1:0] EntryAddr    = AddrWidth'(c_entry_addr),
    parameter logic [AddrWidth-1:0] WakeAddr     = AddrWidth'(c_wake_addr),
    parameter int unsigned          PollInterval = 1024
`ifdef PB_BOOT_SEQ_TIMEOUT_EN
    ,
    parameter logic [31:0]          TimeoutCycles = c_timeout_cycles
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [1:0]           boot_mode_i,
    input  logic                 preload_done_i,
    input  logic [AddrWidth-1:0] entry_i,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 we_o,
    output logic [DataWidth-1:0] wdata_o,
    input  logic                 rvalid_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          exit_code_o,
    output logic                 error_o
);

    localparam logic [31:0] c_poll_terminal = 32'(PollInterval - 1);

    boot_state_e          r_state;
    boot_state_e          w_state_next;
    logic [AddrWidth-1:0] r_entry;
    logic [31:0]          r_exit_code;
    logic                 w_busy;
    logic                 w_start_accept;
    logic                 w_poll_expire;
    logic                 w_timeout;
    logic                 w_eoc;
    logic                 w_unused_rdata;

    assign w_busy         = !(r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign w_start_accept = start_i && !w_busy;
    // A response is only taken in POLL_RESP, so one arriving with the grant is dropped
    assign w_eoc          = (r_state == ST_POLL_RESP) && rvalid_i && rdata_i[0];
    // Only bits [32:0] of the scratch word carry meaning
    assign w_unused_rdata = ^rdata_i[DataWidth-1:33];

    // Poll interval: held at zero outside POLL_WAIT so every wait starts fresh
    pb_boot_seq_timer #(
        .WIDTH      (32)
    ) u_poll_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (r_state != ST_POLL_WAIT),
        .i_enable   (r_state == ST_POLL_WAIT),
        .i_terminal (c_poll_terminal),
        .o_expire   (w_poll_expire)
    );

`ifdef PB_BOOT_SEQ_TIMEOUT_EN
    localparam logic [31:0] c_timeout_terminal = TimeoutCycles - 32'd1;

    // Watchdog: runs across every busy state, cleared whenever the sequencer rests
    pb_boot_seq_timer #(
        .WIDTH      (32)
    ) u_timeout_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_load     (!w_busy),
        .i_enable   (w_busy),
        .i_terminal (c_timeout_terminal),
        .o_expire   (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; the watchdog overrides any busy-state transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    case (boot_mode_e'(boot_mode_i))
                        IDLE_PRELOAD: w_state_next = ST_WAIT_PRE;
                        SDCARD:       w_state_next = ST_ERROR;
                        default:      w_state_next = ST_POLL_WAIT;
                    endcase
                end
            end
            ST_WAIT_PRE:  if (preload_done_i) w_state_next = ST_WR_ENTRY;
            ST_WR_ENTRY:  if (gnt_i)          w_state_next = ST_WR_WAKE;
            ST_WR_WAKE:   if (gnt_i)          w_state_next = ST_POLL_WAIT;
            ST_POLL_WAIT: if (w_poll_expire)  w_state_next = ST_POLL_REQ;
            ST_POLL_REQ:  if (gnt_i)          w_state_next = ST_POLL_RESP;
            ST_POLL_RESP: begin
                if (rvalid_i) begin
                    w_state_next = rdata_i[0] ? ST_DONE : ST_POLL_WAIT;
                end
            end
            default:      w_state_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = ST_ERROR;
        end
    end

    // Entry point captured at start so the request stays stable while stalled
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_entry <= '0;
        end else if (w_start_accept) begin
            r_entry <= entry_i;
        end
    end

    // Exit code: cleared by an accepted start, set by EOC or watchdog expiry
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_exit_code <= '0;
        end else if (w_start_accept) begin
            r_exit_code <= '0;
        end else if (w_timeout) begin
            r_exit_code <= c_timeout_code;
        end else if (w_eoc) begin
            r_exit_code <= rdata_i[32:1];
        end
    end

    // Output decode: bus fields are driven only in request states, zero elsewhere
    always_comb begin
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        busy_o  = w_busy;
        done_o  = (r_state == ST_DONE);
        error_o = (r_state == ST_ERROR);
        case (r_state)
            ST_WR_ENTRY: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = EntryAddr;
                wdata_o = DataWidth'(r_entry);
            end
            ST_WR_WAKE: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = WakeAddr;
                wdata_o = DataWidth'(1);
            end
            ST_POLL_REQ: begin
                req_o   = 1'b1;
                addr_o  = ScratchAddr;
            end
            default: ;
        endcase
    end

    assign exit_code_o = r_exit_code;

endmodule
`default_nettype wire

// File: doc/pb_boot_seq.md
PB_BOOT_SEQ -- requirements
Module: pb_boot_seq

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, memory-port address width.
REQ-002 SHALL have parameter DataWidth, default 64, memory-port data width.
REQ-003 SHALL have parameter ScratchAddr, default 48'h0300_0000, EOC scratch register address.
REQ-004 SHALL have parameter EntryAddr, default 48'h0300_0008, core entry-point register address.
REQ-005 SHALL have parameter WakeAddr, default 48'h0300_0010, core wake-up register address.
REQ-006 SHALL have parameter PollInterval, default 1024, idle cycles between EOC polls (>=1).
REQ-007 SHALL have ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle sequence start pulse.
- boot_mode_i  in  2  0 idle/preload, 1 SD (unsupported), 2/3 autonomous.
- preload_done_i  in  1  level, external preload finished.
- entry_i  in  AddrWidth  entry address written in idle mode.
- req_o  out  1  memory request.
- gnt_i  in  1  request accepted.
- addr_o  out  AddrWidth  request address.
- we_o  out  1  write enable.
- wdata_o  out  DataWidth  write data.
- rvalid_i  in  1  read response valid.
- rdata_i  in  DataWidth  read response data.
- busy_o  out  1  sequence in progress.
- done_o  out  1  EOC seen, sticky until next start_i.
- exit_code_o  out  32  rdata_i[32:1] captured at EOC.
- error_o  out  1  unsupported mode or timeout, sticky until next start_i.

Function
REQ-010 SHALL implement states IDLE, WAIT_PRE, WR_ENTRY, WR_WAKE, POLL_WAIT, POLL_REQ, POLL_RESP, DONE, ERROR.
REQ-011 IDLE + start_i SHALL latch boot_mode_i and entry_i; mode 0 -> WAIT_PRE, mode 1 -> ERROR, mode 2/3 -> POLL_WAIT, all next cycle.
REQ-012 WAIT_PRE SHALL go to WR_ENTRY in the cycle after preload_done_i is sampled high.
REQ-013 WR_ENTRY SHALL drive req_o=1, we_o=1, addr_o=EntryAddr, wdata_o=zero-extended latched entry; advance to WR_WAKE on gnt_i.
REQ-014 WR_WAKE SHALL write wdata_o=1 to WakeAddr; advance to POLL_WAIT on gnt_i.
REQ-015 req_o, addr_o, we_o, wdata_o SHALL stay stable while req_o=1 and gnt_i=0; req_o SHALL drop the cycle after gnt_i.
REQ-016 POLL_WAIT SHALL count PollInterval cycles, then go to POLL_REQ.
REQ-017 POLL_REQ SHALL issue read (we_o=0, addr_o=ScratchAddr); on gnt_i -> POLL_RESP.
REQ-018 POLL_RESP on rvalid_i: rdata_i[0]=1 -> DONE, capture exit_code_o; else -> POLL_WAIT with counter reset.
REQ-019 rvalid_i in same cycle as gnt_i SHALL NOT be accepted; at most one request outstanding.
REQ-020 DONE SHALL assert done_o, busy_o=0; start_i in DONE or ERROR SHALL clear done_o/error_o/exit_code_o and restart per REQ-011.
REQ-021 start_i while busy_o=1 SHALL be ignored.
REQ-022 busy_o SHALL be 1 in every state except IDLE, DONE, ERROR.
REQ-023 Non-request states SHALL drive req_o=0, we_o=0, addr_o=0, wdata_o=0.

Reset
REQ-030 rst_ni low at a clock edge SHALL force IDLE, counters 0, all outputs 0, including mid-transaction (pending gnt_i/rvalid_i ignored afterwards).

Configuration
REQ-040 With PB_BOOT_SEQ_TIMEOUT_EN defined, a 32-bit counter (parameter TimeoutCycles, default 32'd10_000_000) SHALL run in all busy states; on expiry -> ERROR with exit_code_o=32'hFFFF_FFFF.
REQ-041 Without PB_BOOT_SEQ_TIMEOUT_EN, no timeout logic SHALL exist and polling SHALL continue indefinitely.

Structure
REQ-050 Package pb_boot_seq_pkg SHALL hold the state enum, boot-mode enum (IDLE_PRELOAD=0, SDCARD=1, AUTO_SPI=2, AUTO_I2C=3) and default register-address constants.
REQ-051 Poll-interval and timeout counting SHALL reside in one sub-module pb_boot_seq_timer (load, enable, expire).

Verification
REQ-060 mode 0, entry 0x8000_0000, preload_done_i after 50 cycles, gnt_i immediate -> writes 0x8000_0000@EntryAddr then 1@WakeAddr, polls every 1024 cycles.
REQ-061 poll returns rdata 0x0 twice then 0x5 -> done_o=1, exit_code_o=2, busy_o=0, no further requests.
REQ-062 mode 1 start -> error_o=1 next cycle, req_o never asserted.
REQ-063 mode 2, gnt_i delayed 7 cycles -> no writes, addr_o/we_o stable during stall, first read after 1024 cycles.
REQ-064 rst_ni low during POLL_RESP -> IDLE, outputs 0; late rvalid_i ignored.
REQ-065 with PB_BOOT_SEQ_TIMEOUT_EN, TimeoutCycles=5000, EOC never set -> error_o=1, exit_code_o=0xFFFF_FFFF at cycle 5000.
